system_motor_rst_seq: RTL

SYSTEM_MOTOR_RST_SEQ -- requirements
Module: system_motor_rst_seq

---
 rtl/system_motor_rst_pkg.sv | 31 +++
 rtl/system_motor_rst_cnt.sv | 40 ++++
 rtl/system_motor_rst_seq.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/system_motor_rst_pkg.sv
`default_nettype none
// ============================================================================
// Module      : system_motor_rst_pkg
// Description : Shared definitions for the motor reset sequencer: the register
//               map, the CTRL bit positions and the sequencer FSM encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package system_motor_rst_pkg;

  // Register map (word addresses on the 2-bit Avalon-MM address bus)
  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PW     = 2'd1;
  localparam logic [1:0] ADDR_GAP    = 2'd2;
  localparam logic [1:0] ADDR_MANUAL = 2'd3;

  // CTRL register bit positions
  localparam int CTRL_START_BIT = 0;  // write: start sequence; read: busy
  localparam int CTRL_DONE_BIT  = 1;  // write: W1C done;       read: done
  localparam int CTRL_IRQEN_BIT = 2;  // read/write: interrupt enable
  localparam int CTRL_MASK_LSB  = 8;  // [15:8] channel mask
  localparam int CTRL_MRST_LSB  = 16; // [23:16] motor_rst readback (read only)

  // Sequencer FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

endpackage : system_motor_rst_pkg
`default_nettype wire

// File: rtl/system_motor_rst_cnt.sv
`default_nettype none
// ============================================================================
// Module      : system_motor_rst_cnt
// Description : Loadable down-counter with a zero flag. Used for both the
//               reset-assert duration and the gap between channel releases.
// Ports       : clk      - clock
//               reset_n  - asynchronous active-low reset (count -> 0)
//               load     - load load_val (has priority over en)
//               load_val - value to load
//               en       - decrement by one, saturating at zero
//               zero     - count == 0
// Revision    : 1.0 - initial release
// ============================================================================
module system_motor_rst_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule : system_motor_rst_cnt
`default_nettype wire

// File: rtl/system_motor_rst_seq.sv
`default_nettype none
// ============================================================================
// Module      : system_motor_rst_seq
// Description : Avalon-MM controlled motor reset sequencer. A start command
//               asserts reset on the masked channels for PW cycles, then
//               releases them one by one in ascending order, GAP cycles apart.
// Ports       : clk, reset_n            - clock, async active-low reset
//               address, chipselect,
//               write_n, writedata      - Avalon-MM write side
//               readdata                - combinational read data
//               motor_rst[NUM_CH-1:0]   - 1 = motor held in reset
//               irq                     - done AND irq_en (level)
// Revision    : 1.0 - initial release
// ============================================================================
module system_motor_rst_seq
  import system_motor_rst_pkg::*;
#(
  parameter int NUM_CH = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [NUM_CH-1:0] motor_rst,
  output logic              irq
);

  localparam logic [7:0] CH_MASK = 8'((1 << NUM_CH) - 1);

  state_t            state, state_next;
  logic              busy;
  logic              wr, ctrl_wr;
  logic [7:0]        wr_mask;
  logic [7:0]        mask_reg;
  logic [NUM_CH-1:0] new_mask;
  logic [NUM_CH-1:0] pending, pending_next;
  logic [NUM_CH-1:0] set_bits, clr_bits;
  logic [CNT_W-1:0]  pw_reg, gap_reg, gap_lat;
  logic              done, irq_en;
  logic              set_done, start_seq;
  logic              cnt_load, cnt_en, cnt_zero;
  logic [CNT_W-1:0]  cnt_val;
  logic              unused_wdata;

  // A programmed value N gives N cycles; 0 behaves as 1. The counter runs
  // from N-1 down to 0, one cycle per count.
  function automatic logic [CNT_W-1:0] cycles_to_load(input logic [CNT_W-1:0] v);
    return (v == '0) ? '0 : (v - CNT_W'(1));
  endfunction

  assign wr       = chipselect & ~write_n;
  assign ctrl_wr  = wr && (address == ADDR_CTRL);
  assign wr_mask  = writedata[CTRL_MASK_LSB +: 8] & CH_MASK;
  assign new_mask = wr_mask[NUM_CH-1:0];
  assign busy     = (state != ST_IDLE);
  assign irq      = done & irq_en;

  // Bits outside the implemented fields are don't-care on writes.
  assign unused_wdata = ^writedata;

  system_motor_rst_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (cnt_load),
    .load_val (cnt_val),
    .en       (cnt_en),
    .zero     (cnt_zero)
  );

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next-state and sequencing controls
  // --------------------------------------------------------------------------
  always_comb begin
    state_next   = state;
    pending_next = pending;
    set_bits     = '0;
    clr_bits     = '0;
    set_done     = 1'b0;
    start_seq    = 1'b0;
    cnt_load     = 1'b0;
    cnt_val      = '0;
    cnt_en       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ctrl_wr && writedata[CTRL_START_BIT]) begin
          if (new_mask == '0) begin
            // Nothing to sequence: report completion straight away.
            set_done = 1'b1;
          end else begin
            state_next   = ST_ASSERT;
            set_bits     = new_mask;
            pending_next = new_mask;
            start_seq    = 1'b1;
            cnt_load     = 1'b1;
            cnt_val      = cycles_to_load(pw_reg);
          end
        end
      end
      ST_ASSERT, ST_RELEASE: begin
        if (cnt_zero) begin
          // Isolate the lowest pending channel (two's complement trick).
          clr_bits     = pending & (~pending + NUM_CH'(1));
          pending_next = pending & ~clr_bits;
          if (pending_next == '0) begin
            set_done   = 1'b1;
            state_next = ST_IDLE;
          end else begin
            state_next = ST_RELEASE;
            cnt_load   = 1'b1;
            cnt_val    = cycles_to_load(gap_lat);
          end
        end else begin
          cnt_en = 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers and datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      motor_rst <= '1;
      pending   <= '0;
      mask_reg  <= '0;
      pw_reg    <= CNT_W'(1);
      gap_reg   <= CNT_W'(1);
      gap_lat   <= CNT_W'(1);
      done      <= 1'b0;
      irq_en    <= 1'b0;
    end else begin
      pending <= pending_next;

      // GAP is frozen for the whole sequence; PW is consumed by the load.
      if (start_seq) begin
        gap_lat <= gap_reg;
      end

      if (!busy && wr && (address == ADDR_MANUAL)) begin
        motor_rst <= writedata[NUM_CH-1:0];
      end else begin
        motor_rst <= (motor_rst | set_bits) & ~clr_bits;
      end

      if (!busy && wr && (address == ADDR_PW)) begin
        pw_reg <= writedata[CNT_W-1:0];
      end
      if (!busy && wr && (address == ADDR_GAP)) begin
        gap_reg <= writedata[CNT_W-1:0];
      end

      if (ctrl_wr) begin
        irq_en <= writedata[CTRL_IRQEN_BIT];
        // The mask in use belongs to the running sequence; leave it alone.
        if (!busy) begin
          mask_reg <= wr_mask;
        end
      end

      // Completion outranks a simultaneous W1C.
      if (set_done) begin
        done <= 1'b1;
      end else if (ctrl_wr && writedata[CTRL_DONE_BIT]) begin
        done <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read mux (zero wait states)
  // --------------------------------------------------------------------------
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_CTRL: begin
        readdata[CTRL_START_BIT]           = busy;
        readdata[CTRL_DONE_BIT]            = done;
        readdata[CTRL_IRQEN_BIT]           = irq_en;
        readdata[CTRL_MASK_LSB +: 8]       = mask_reg;
        readdata[CTRL_MRST_LSB +: NUM_CH]  = motor_rst;
      end
      ADDR_PW:     readdata[CNT_W-1:0]  = pw_reg;
      ADDR_GAP:    readdata[CNT_W-1:0]  = gap_reg;
      ADDR_MANUAL: readdata[NUM_CH-1:0] = motor_rst;
      default:     readdata = '0;
    endcase
  end

endmodule : system_motor_rst_seq
`default_nettype wire
